// File: rtl/mem_map_pkg.sv
// Address map constants, target codes and responder FSM states shared by
// the memory bus responder and its address decoder.
package mem_map_pkg;

    localparam int unsigned VGA_BASE = 32'd0;
    localparam int unsigned RAM_BASE = 32'd224000;
    localparam int unsigned RAM_END  = 32'd1272576;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_RAM  = 2'd1,
        TGT_VGA  = 2'd2,
        TGT_ERR  = 2'd3
    } target_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU-side request/response bus and the generic device bus used for the RAM
// and VGA ports of the memory bus responder.
interface cpu_bus_if #(parameter int WORD_WIDTH = 32);
    logic                  req;
    logic                  we;
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  resp_valid;
    logic [WORD_WIDTH-1:0] rdata;
    logic                  err;

    modport master (output req, we, addr, wdata,
                    input  ready, resp_valid, rdata, err);
    modport slave  (input  req, we, addr, wdata,
                    output ready, resp_valid, rdata, err);
endinterface

interface dev_bus_if #(parameter int WORD_WIDTH = 32);
    logic                  req;
    logic                  we;
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  ack;
    logic [WORD_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata,
                    input  ack, rdata);
    modport slave  (input  req, we, addr, wdata,
                    output ack, rdata);
endinterface

// File: rtl/addr_region_decode.sv
// Combinational CPU address decode: selects the target device and produces
// the device-relative offset.
module addr_region_decode
    import mem_map_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] addr,
    output logic [WORD_WIDTH-1:0] offset,
    output target_e               target
);

    localparam logic [WORD_WIDTH-1:0] RAM_LO = WORD_WIDTH'(RAM_BASE);
    localparam logic [WORD_WIDTH-1:0] RAM_HI = WORD_WIDTH'(RAM_END);

    // VGA sits at the bottom of the map, so its offset is the address itself.
    always_comb begin
        offset = '0;
        target = TGT_ERR;
        if (addr < RAM_LO) begin
            target = TGT_VGA;
            offset = addr;
        end else if (addr < RAM_HI) begin
            target = TGT_RAM;
            offset = addr - RAM_LO;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Single-outstanding CPU bus responder: decodes each request to RAM or VGA,
// waits for the device ack (bounded by TIMEOUT) and returns one response.
module mem_bus_responder
    import mem_map_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic      clk,
    input  logic      rst,
    cpu_bus_if.slave  cpu,
    dev_bus_if.master ram,
    dev_bus_if.master vga
);

    localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                  state;
    target_e                 tgt_q;
    logic                    we_q;
    logic [WORD_WIDTH-1:0]   offset_q;
    logic [WORD_WIDTH-1:0]   wdata_q;
    logic [WORD_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    resp_valid_q;
    logic                    ram_req_q;
    logic                    vga_req_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [WORD_WIDTH-1:0]   dec_offset;
    target_e                 dec_target;
    logic                    sel_ack;
    logic [WORD_WIDTH-1:0]   sel_rdata;

    addr_region_decode #(.WORD_WIDTH(WORD_WIDTH)) u_decode (
        .addr   (cpu.addr),
        .offset (dec_offset),
        .target (dec_target)
    );

    // Only the device selected at accept may complete the transaction.
    assign sel_ack   = (tgt_q == TGT_RAM) ? ram.ack   : (tgt_q == TGT_VGA) ? vga.ack : 1'b0;
    assign sel_rdata = (tgt_q == TGT_RAM) ? ram.rdata : vga.rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tgt_q        <= TGT_NONE;
            we_q         <= 1'b0;
            offset_q     <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            ram_req_q    <= 1'b0;
            vga_req_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu.req) begin
                        we_q     <= cpu.we;
                        wdata_q  <= cpu.wdata;
                        tgt_q    <= dec_target;
                        offset_q <= dec_offset;
                        cnt_q    <= '0;
                        if (dec_target == TGT_ERR) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= 1'b1;
                            rdata_q      <= '0;
                        end else begin
                            state     <= BUSY;
                            ram_req_q <= (dec_target == TGT_RAM);
                            vga_req_q <= (dec_target == TGT_VGA);
                        end
                    end
                end
                BUSY: begin
                    // An ack on the timeout edge still completes normally.
                    if (sel_ack) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        ram_req_q    <= 1'b0;
                        vga_req_q    <= 1'b0;
                        err_q        <= 1'b0;
                        rdata_q      <= we_q ? '0 : sel_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        ram_req_q    <= 1'b0;
                        vga_req_q    <= 1'b0;
                        err_q        <= 1'b1;
                        rdata_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cpu.ready      = (state == IDLE);
    assign cpu.resp_valid = resp_valid_q;
    assign cpu.rdata      = rdata_q;
    assign cpu.err        = err_q;

    assign ram.req   = ram_req_q;
    assign ram.we    = we_q;
    assign ram.addr  = offset_q;
    assign ram.wdata = wdata_q;

    assign vga.req   = vga_req_q;
    assign vga.we    = we_q;
    assign vga.addr  = offset_q;
    assign vga.wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder: a transaction-level model of the
// address map and response timing drives expectations checked every cycle.
module tb_mem_bus_responder;
    import mem_map_pkg::*;

    localparam int W  = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_bus_if #(.WORD_WIDTH(W)) cpu_b ();
    dev_bus_if #(.WORD_WIDTH(W)) ram_b ();
    dev_bus_if #(.WORD_WIDTH(W)) vga_b ();

    mem_bus_responder #(.WORD_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .cpu (cpu_b),
        .ram (ram_b),
        .vga (vga_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic         e_ready, e_rv, e_err, e_ram_req, e_vga_req, e_we;
    logic [W-1:0] e_rdata, e_addr, e_wdata;

    logic [W-1:0] seen_addr, seen_rdata;
    logic         seen_we, seen_err, seen_rv;
    int           req_cycles;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_ready   = 1'b1;
        e_rv      = 1'b0;
        e_ram_req = 1'b0;
        e_vga_req = 1'b0;
    endtask

    // Address map from the memory map: 1 = RAM, 2 = VGA, 3 = error.
    function automatic void map_addr(input logic [W-1:0] a, output int tgt, output logic [W-1:0] off);
        if (a < 32'd224000) begin
            tgt = 2;
            off = a;
        end else if (a < 32'd1272576) begin
            tgt = 1;
            off = a - 32'd224000;
        end else begin
            tgt = 3;
            off = '0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_ready", {31'd0, cpu_b.ready}, {31'd0, e_ready});
            chk("cpu_resp_valid", {31'd0, cpu_b.resp_valid}, {31'd0, e_rv});
            chk("cpu_err", {31'd0, cpu_b.err}, {31'd0, e_err});
            chk("cpu_rdata", cpu_b.rdata, e_rdata);
            chk("ram_req", {31'd0, ram_b.req}, {31'd0, e_ram_req});
            chk("vga_req", {31'd0, vga_b.req}, {31'd0, e_vga_req});
            if (e_ram_req) begin
                chk("ram_addr", ram_b.addr, e_addr);
                chk("ram_we", {31'd0, ram_b.we}, {31'd0, e_we});
                chk("ram_wdata", ram_b.wdata, e_wdata);
            end
            if (e_vga_req) begin
                chk("vga_addr", vga_b.addr, e_addr);
                chk("vga_we", {31'd0, vga_b.we}, {31'd0, e_we});
                chk("vga_wdata", vga_b.wdata, e_wdata);
            end
        end
    end

    // ack_at: BUSY cycle (1-based) in which the selected device acks; 0 = never.
    task automatic run_txn(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wd,
                           input int ack_at, input logic [W-1:0] rd, input bit stray);
        int           tgt, k;
        logic [W-1:0] off, n_rd;
        logic         n_err;
        bit           done;
        map_addr(addr, tgt, off);
        req_cycles = 0;
        seen_addr  = '0;
        seen_we    = 1'b0;
        n_err      = 1'b1;
        n_rd       = '0;
        set_idle_exp();
        cpu_b.req   = 1'b1;
        cpu_b.we    = we;
        cpu_b.addr  = addr;
        cpu_b.wdata = wd;
        ram_b.ack   = 1'($urandom);
        vga_b.ack   = 1'($urandom);
        ram_b.rdata = $urandom;
        vga_b.rdata = $urandom;
        step();
        cpu_b.req   = 1'b0;
        cpu_b.we    = 1'($urandom);
        cpu_b.addr  = $urandom;
        cpu_b.wdata = $urandom;
        if (tgt != 3) begin
            k    = 1;
            done = 1'b0;
            while (!done) begin
                e_ready   = 1'b0;
                e_rv      = 1'b0;
                e_ram_req = (tgt == 1);
                e_vga_req = (tgt == 2);
                e_addr    = off;
                e_we      = we;
                e_wdata   = wd;
                if (ram_b.req || vga_b.req) req_cycles++;
                if (k == 1) begin
                    seen_addr = (tgt == 1) ? ram_b.addr : vga_b.addr;
                    seen_we   = (tgt == 1) ? ram_b.we : vga_b.we;
                end
                ram_b.rdata = $urandom;
                vga_b.rdata = $urandom;
                if (tgt == 1) begin
                    ram_b.ack = (k == ack_at);
                    vga_b.ack = stray & 1'($urandom);
                    if (k == ack_at) ram_b.rdata = rd;
                end else begin
                    vga_b.ack = (k == ack_at);
                    ram_b.ack = stray & 1'($urandom);
                    if (k == ack_at) vga_b.rdata = rd;
                end
                if (k == ack_at) begin
                    n_err = 1'b0;
                    n_rd  = we ? '0 : rd;
                    done  = 1'b1;
                end else if (k == TO) begin
                    n_err = 1'b1;
                    n_rd  = '0;
                    done  = 1'b1;
                end
                step();
                k++;
            end
        end
        ram_b.ack   = 1'($urandom);
        vga_b.ack   = 1'($urandom);
        e_ready     = 1'b0;
        e_rv        = 1'b1;
        e_err       = n_err;
        e_rdata     = n_rd;
        e_ram_req   = 1'b0;
        e_vga_req   = 1'b0;
        seen_rv     = cpu_b.resp_valid;
        seen_err    = cpu_b.err;
        seen_rdata  = cpu_b.rdata;
        if (ram_b.req || vga_b.req) req_cycles++;
        cpu_b.req   = 1'($urandom);
        step();
        cpu_b.req   = 1'b0;
        ram_b.ack   = 1'b0;
        vga_b.ack   = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] edges [6];
        edges[0] = 32'd0;       edges[1] = 32'd223999; edges[2] = 32'd224000;
        edges[3] = 32'd1272575; edges[4] = 32'd1272576; edges[5] = 32'hFFFF_FFFF;

        cpu_b.req = 1'b0; cpu_b.we = 1'b0; cpu_b.addr = '0; cpu_b.wdata = '0;
        ram_b.ack = 1'b0; ram_b.rdata = '0; vga_b.ack = 1'b0; vga_b.rdata = '0;
        set_idle_exp();
        e_err = 1'b0; e_rdata = '0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_ready", {31'd0, cpu_b.ready}, 32'd1);
        chk("reset_resp_valid", {31'd0, cpu_b.resp_valid}, 32'd0);
        chk("reset_reqs", {30'd0, ram_b.req, vga_b.req}, 32'd0);
        rst = 1'b0;
        step();

        run_txn(1'b0, 32'd223999, 32'h0, 3, 32'hABCD, 1'b0);
        chk("vga_rd_addr", seen_addr, 32'd223999);
        chk("vga_rd_req_cycles", req_cycles, 32'd3);
        chk("vga_rd_resp_valid", {31'd0, seen_rv}, 32'd1);
        chk("vga_rd_rdata", seen_rdata, 32'hABCD);
        chk("vga_rd_err", {31'd0, seen_err}, 32'd0);

        run_txn(1'b1, 32'd224000, 32'h5555_AAAA, 2, 32'hDEAD_BEEF, 1'b0);
        chk("ram_wr_lo_addr", seen_addr, 32'd0);
        chk("ram_wr_lo_we", {31'd0, seen_we}, 32'd1);
        chk("ram_wr_lo_rdata", seen_rdata, 32'd0);
        chk("ram_wr_lo_err", {31'd0, seen_err}, 32'd0);

        run_txn(1'b1, 32'd1272575, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1'b0);
        chk("ram_wr_hi_addr", seen_addr, 32'd1048575);
        chk("ram_wr_hi_rdata", seen_rdata, 32'd0);

        run_txn(1'b0, 32'd1272576, 32'h0, 1, 32'h0, 1'b0);
        chk("unmapped_req_cycles", req_cycles, 32'd0);
        chk("unmapped_resp_valid", {31'd0, seen_rv}, 32'd1);
        chk("unmapped_err", {31'd0, seen_err}, 32'd1);

        run_txn(1'b0, 32'd500000, 32'h0, 0, 32'h0, 1'b1);
        chk("timeout_req_cycles", req_cycles, 32'd4);
        chk("timeout_err", {31'd0, seen_err}, 32'd1);
        chk("timeout_rdata", seen_rdata, 32'd0);

        run_txn(1'b0, 32'd600000, 32'h0, TO, 32'h1234, 1'b1);
        chk("tie_err", {31'd0, seen_err}, 32'd0);
        chk("tie_rdata", seen_rdata, 32'h1234);

        // Stray VGA ack during a RAM read, then reset in the middle of BUSY.
        set_idle_exp();
        cpu_b.req = 1'b1; cpu_b.we = 1'b0; cpu_b.addr = 32'd300000; cpu_b.wdata = 32'h77;
        step();
        cpu_b.req = 1'b0;
        e_ready = 1'b0; e_ram_req = 1'b1; e_addr = 32'd76000; e_we = 1'b0; e_wdata = 32'h77;
        step();
        vga_b.ack = 1'b1;
        step();
        vga_b.ack = 1'b0;
        chk("stray_ack_ram_req", {31'd0, ram_b.req}, 32'd1);
        rst = 1'b1;
        set_idle_exp();
        e_err = 1'b0; e_rdata = '0;
        #1;
        chk("async_rst_ram_req", {31'd0, ram_b.req}, 32'd0);
        chk("async_rst_resp_valid", {31'd0, cpu_b.resp_valid}, 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_ready", {31'd0, cpu_b.ready}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 223999);
                1:       a = $urandom_range(224000, 1272575);
                2:       a = $urandom;
                default: a = edges[$urandom_range(0, 5)];
            endcase
            run_txn(1'($urandom), a, $urandom, $urandom_range(0, TO + 1), $urandom, 1'($urandom));
        end

        repeat (2) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the width of address and data buses.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles to wait for a device ack.
REQ-003 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 cpu_req  in  1  CPU request valid.
REQ-006 cpu_we  in  1  1 means write, 0 means read.
REQ-007 cpu_addr  in  WORD_WIDTH  untranslated CPU address.
REQ-008 cpu_wdata  in  WORD_WIDTH  write data.
REQ-009 cpu_ready  out  1  responder idle; request accepted when cpu_req and cpu_ready are both high at an edge.
REQ-010 cpu_resp_valid  out  1  one-cycle response strobe.
REQ-011 cpu_rdata  out  WORD_WIDTH  read data, qualified by cpu_resp_valid.
REQ-012 cpu_err  out  1  response is an error (unmapped address or timeout).
REQ-013 ram_req, ram_we  out  1 each  RAM request and direction; ram_addr, ram_wdata  out  WORD_WIDTH.
REQ-014 ram_ack  in  1, ram_rdata  in  WORD_WIDTH  RAM completion and read data.
REQ-015 vga_req, vga_we, vga_addr, vga_wdata, vga_ack, vga_rdata SHALL mirror the RAM port set for the VGA device.

Function
REQ-016 Address map: [0, 224000) SHALL go to VGA with offset addr; [224000, 1272576) SHALL go to RAM with offset addr-224000; all other addresses SHALL be an error.
REQ-017 FSM states SHALL be IDLE, BUSY and RESP; cpu_ready SHALL be high only in IDLE.
REQ-018 On accept, the responder SHALL register we, wdata, target and offset in the same edge.
REQ-019 Accept to a mapped region SHALL go to BUSY; accept to an unmapped address SHALL go directly to RESP with cpu_err=1, cpu_rdata=0, and SHALL assert no device request.
REQ-020 In BUSY, the selected device's req SHALL be high with addr/we/wdata held stable; the other device's req SHALL stay low.
REQ-021 If the selected ack is sampled high at an edge, req SHALL drop the next cycle, the state SHALL go to RESP, and rdata SHALL be captured for reads or set to 0 for writes.
REQ-022 An ack from the unselected device, or any ack outside BUSY, SHALL be ignored.
REQ-023 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-024 When the count reaches TIMEOUT, req SHALL drop, the state SHALL go to RESP, and cpu_err=1, cpu_rdata=0.
REQ-025 If ack and timeout occur on the same edge, ack SHALL win with cpu_err=0.
REQ-026 In RESP, cpu_resp_valid SHALL be high for exactly one cycle, then the state SHALL return to IDLE.
REQ-027 cpu_rdata and cpu_err SHALL hold their values until the next response.
REQ-028 Latency: error response SHALL be 1 cycle after accept; device response SHALL be 1 cycle after the ack edge.
REQ-029 Back-to-back: a new request SHALL be accepted no earlier than the IDLE cycle following RESP.

Reset
REQ-030 rst SHALL immediately force IDLE and clear all of: req, cpu_resp_valid, cpu_err, cpu_rdata, timeout count and registered fields.
REQ-031 Reset mid-BUSY SHALL drop device req asynchronously and SHALL produce no response.

Structure
REQ-032 Package mem_map_pkg SHALL hold VGA_BASE=0, RAM_BASE=224000, RAM_END=1272576, target codes RAM=1, VGA=2, ERR=3, and the FSM state enum.
REQ-033 The combinational map SHALL live in one sub-module addr_region_decode (addr -> offset, target code), instantiated once on cpu_addr.

Verification
REQ-034 Read at 223999 with vga_ack after 3 cycles, vga_rdata=0xABCD -> vga_addr=223999; resp_valid 1 cycle after ack; rdata=0xABCD; err=0.
REQ-035 Write at 224000 and at 1272575 -> ram_addr=0 then 1048575; ram_we=1; rdata=0; err=0.
REQ-036 Read at 1272576 -> no ram_req or vga_req; resp_valid 1 cycle after accept; err=1.
REQ-037 RAM read with no ack, TIMEOUT=4 -> ram_req drops after 4 BUSY cycles; err=1; rdata=0.
REQ-038 Stray vga_ack during a RAM transaction, then rst mid-BUSY -> ack ignored; req low immediately; no resp_valid; cpu_ready=1 after reset release.
